// File: rtl/sdram_bus_bridge.sv
// Bridges the PicoRV32 valid/ready handshake onto the SDRAM controller's held request,
// aligned to clkref and with periodic refresh slots. Optional read buffer: SDRAM_RDBUF_EN.
`timescale 1ns/1ps
module sdram_bus_bridge #(
  parameter int unsigned ADDR_BITS        = 26,
  parameter int unsigned REFRESH_INTERVAL = 780,
  parameter int unsigned REFRESH_HOLD     = 40
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clkref,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wstrb,
  output logic [31:0]          mem_rdata,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_we,
  output logic                 ram_oe,
  output logic [3:0]           ram_dqm,
  output logic [31:0]          ram_din,
  input  logic [31:0]          ram_dout,
  input  logic                 ram_ready
);

  localparam int unsigned CNT_W  = $clog2(REFRESH_INTERVAL + 1);
  localparam int unsigned HOLD_W = (REFRESH_HOLD > 1) ? $clog2(REFRESH_HOLD) : 1;

  typedef enum logic [2:0] {IDLE, ARM, BUSY, DRAIN, REFRESH} state_t;

  state_t                 state;
  logic                   clkref_q;
  logic                   rise;
  logic [CNT_W-1:0]       ref_cnt;
  logic                   refresh_pending;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   is_write;
  logic [ADDR_BITS-3:0]   word;
  logic                   unused_addr_bits;

  assign rise             = clkref & ~clkref_q;
  assign word             = mem_addr[ADDR_BITS-1:2];
  assign unused_addr_bits = ^{mem_addr[31:ADDR_BITS], mem_addr[1:0]};

`ifdef SDRAM_RDBUF_EN
  logic                 buf_valid;
  logic [ADDR_BITS-3:0] buf_word;
  logic [31:0]          buf_data;
  logic                 buf_hit;

  assign buf_hit = buf_valid && (buf_word == word);

  // Refilled by every SDRAM read; writes to the buffered word patch it so it never goes stale.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      buf_word  <= '0;
      buf_data  <= '0;
    end else if (state == BUSY && ram_ready && !is_write) begin
      buf_valid <= 1'b1;
      buf_word  <= ram_addr[ADDR_BITS-1:2];
      buf_data  <= ram_dout;
    end else if (state == IDLE && !refresh_pending && mem_valid && (|mem_wstrb) && buf_hit) begin
      for (int unsigned i = 0; i < 4; i++)
        if (mem_wstrb[i]) buf_data[8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      clkref_q        <= 1'b0;
      ref_cnt         <= CNT_W'(REFRESH_INTERVAL);
      refresh_pending <= 1'b0;
      hold_cnt        <= '0;
      is_write        <= 1'b0;
      mem_ready       <= 1'b0;
      mem_rdata       <= '0;
      ram_addr        <= '0;
      ram_we          <= 1'b0;
      ram_oe          <= 1'b0;
      ram_dqm         <= '0;
      ram_din         <= '0;
    end else begin
      clkref_q  <= clkref;
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (refresh_pending) begin
            refresh_pending <= 1'b0;
            hold_cnt        <= HOLD_W'(REFRESH_HOLD - 1);
            state           <= REFRESH;
          end else if (mem_valid) begin
`ifdef SDRAM_RDBUF_EN
            if (buf_hit && !(|mem_wstrb)) begin
              mem_rdata <= buf_data;
              mem_ready <= 1'b1;
              state     <= DRAIN;
            end else
`endif
            begin
              ram_addr <= {word, 2'b00};
              ram_din  <= mem_wdata;
              ram_dqm  <= (|mem_wstrb) ? ~mem_wstrb : 4'b0000;
              is_write <= |mem_wstrb;
              state    <= ARM;
            end
          end
        end
        ARM: begin
          if (rise) begin
            ram_we <= is_write;
            ram_oe <= ~is_write;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (ram_ready) begin
            mem_rdata <= ram_dout;
            mem_ready <= 1'b1;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (!ram_ready) state <= IDLE;
        end
        REFRESH: begin
          if (hold_cnt == '0) state <= IDLE;
          else hold_cnt <= hold_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
      // After the case so an expiry on the same clock the FSM consumes a refresh is not lost.
      if (ref_cnt == '0) begin
        refresh_pending <= 1'b1;
        ref_cnt         <= CNT_W'(REFRESH_INTERVAL);
      end else begin
        ref_cnt <= ref_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_bus_bridge.sv
// Randomised bench for sdram_bus_bridge: CPU driver tasks, a behavioural SDRAM controller,
// and a word-level reference memory predicting every read.
`timescale 1ns/1ps
module tb_sdram_bus_bridge;

  localparam int unsigned AB = 26;
  localparam int unsigned RI = 50;
  localparam int unsigned RH = 40;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          clkref = 1'b1;
  logic          mem_valid = 1'b0;
  logic          mem_ready;
  logic [31:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [3:0]    mem_wstrb = '0;
  logic [31:0]   mem_rdata;
  logic [AB-1:0] ram_addr;
  logic          ram_we;
  logic          ram_oe;
  logic [3:0]    ram_dqm;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout = '0;
  logic          ram_ready = 1'b0;

  sdram_bus_bridge #(.ADDR_BITS(AB), .REFRESH_INTERVAL(RI), .REFRESH_HOLD(RH)) dut (
    .clk(clk), .resetn(resetn), .clkref(clkref),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_oe(ram_oe), .ram_dqm(ram_dqm),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0] ref_mem [int unsigned];
  logic [31:0] ctl_mem [int unsigned];
  bit          rb_valid = 1'b0;
  int unsigned rb_word = 0;

  function automatic logic [31:0] init_word(input int unsigned w);
    return 32'hC0DE_0000 ^ (32'(w) * 32'h0001_0003);
  endfunction

  function automatic logic [31:0] ref_read(input int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  // ---------------- monitor, controller model, clkref source ----------------
  int unsigned phase = 0;
  bit          req_q = 1'b0;
  logic [66:0] held;
  int unsigned nreq = 0, nready = 0;
  bit          gap_mon = 1'b0, req_seen = 1'b0;
  int unsigned gap = 0, long_gaps = 0;
  int unsigned cst = 0, ccnt = 0;

  always @(negedge clk) begin
    logic req;
    int unsigned w;
    logic [31:0] d;
    req = ram_we | ram_oe;
    if (req && !req_q) begin
      nreq++;
      vectors++;
      if (phase != 0) begin
        miscompares++;
        $display("FAIL req_align: request rose at clkref phase %0d, required phase 0", phase);
      end
      if (gap_mon && req_seen && gap > 25) begin
        long_gaps++;
        vectors++;
        if (gap < RH + 2) begin
          miscompares++;
          $display("FAIL refresh_hold: idle gap %0d clocks, required >= %0d", gap, RH + 2);
        end
      end
      req_seen = 1'b1;
      gap = 0;
      held = {ram_addr, ram_din, ram_dqm, ram_we, ram_oe};
    end else if (req) begin
      vectors++;
      if ({ram_addr, ram_din, ram_dqm, ram_we, ram_oe} !== held) begin
        miscompares++;
        $display("FAIL req_stable: got %h, required %h", {ram_addr, ram_din, ram_dqm, ram_we, ram_oe}, held);
      end
    end else begin
      gap++;
    end
    if (!resetn) req_seen = 1'b0;
    if (mem_ready) nready++;
    req_q = req;

    if (!resetn) begin
      cst = 0;
      ram_ready = 1'b0;
    end else begin
      case (cst)
        0: if (req) begin ccnt = $urandom_range(1, 8); cst = 1; end
        1: begin
          ccnt--;
          if (ccnt == 0) begin
            w = ram_addr[AB-1:2];
            d = ctl_mem.exists(w) ? ctl_mem[w] : init_word(w);
            if (ram_we) begin
              for (int unsigned i = 0; i < 4; i++)
                if (!ram_dqm[i]) d[8*i +: 8] = ram_din[8*i +: 8];
              ctl_mem[w] = d;
              ram_dout = $urandom;
            end else begin
              ram_dout = d;
            end
            ram_ready = 1'b1;
            cst = 2;
          end
        end
        2: cst = 3;
        default: begin ram_ready = 1'b0; cst = 0; end
      endcase
    end

    phase = (phase + 1) % 16;
    clkref = (phase < 8);
  end

  // ---------------- CPU access with inline expectations ----------------
  task automatic access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    int unsigned w, lat;
    logic [31:0] exp, m;
    bit saw_req, hit;
    logic [66:0] want;
    w = addr[AB-1:2];
    exp = ref_read(w);
    hit = 1'b0;
`ifdef SDRAM_RDBUF_EN
    hit = (wstrb == 4'b0000) && rb_valid && (rb_word == w);
`endif
    if (wstrb != 4'b0000) begin
      m = exp;
      for (int unsigned i = 0; i < 4; i++)
        if (wstrb[i]) m[8*i +: 8] = wdata[8*i +: 8];
      ref_mem[w] = m;
    end
    want = {addr[AB-1:2], 2'b00, (wstrb != 0) ? wdata : 32'h0,
            (wstrb != 0) ? ~wstrb : 4'b0000, wstrb != 0, wstrb == 0};
    mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb; mem_valid = 1'b1;
    lat = 0; saw_req = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (!saw_req && (ram_we | ram_oe)) begin
        saw_req = 1'b1;
        vectors++;
        if ({ram_addr, (wstrb != 0) ? ram_din : 32'h0, ram_dqm, ram_we, ram_oe} !== want) begin
          miscompares++;
          $display("FAIL req_fields: got %h, required %h", {ram_addr, ram_din, ram_dqm, ram_we, ram_oe}, want);
        end
      end
    end while (!mem_ready && lat < 300);
    mem_valid = 1'b0;
    vectors++;
    if (mem_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_timeout: no mem_ready within %0d clocks for addr %h", lat, addr);
    end
    vectors++;
    if ((ram_we | ram_oe) !== 1'b0) begin
      miscompares++;
      $display("FAIL req_drop: request %b at mem_ready, required 0", {ram_we, ram_oe});
    end
    if (wstrb == 4'b0000) begin
      vectors++;
      if (mem_rdata !== exp) begin
        miscompares++;
        $display("FAIL rdata: addr %h got %h, required %h", addr, mem_rdata, exp);
      end
    end
    vectors++;
    if (saw_req !== !hit) begin
      miscompares++;
      $display("FAIL sdram_req: addr %h request seen %0d, required %0d", addr, saw_req, !hit);
    end
    if (hit) begin
      vectors++;
      if (!(lat == 1 || lat >= RH)) begin
        miscompares++;
        $display("FAIL hit_latency: %0d clocks, required 1 (or a refresh slot)", lat);
      end
    end
    @(negedge clk);
    vectors++;
    if (mem_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_pulse: mem_ready %b one clock later, required 0", mem_ready);
    end
    if (wstrb == 4'b0000 && !hit) begin rb_valid = 1'b1; rb_word = w; end
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if ({mem_ready, mem_rdata, ram_we, ram_oe, ram_addr, ram_dqm, ram_din} !== '0) begin
      miscompares++;
      $display("FAIL %s: outputs %h, required all 0", tag,
               {mem_ready, mem_rdata, ram_we, ram_oe, ram_addr, ram_dqm, ram_din});
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read;
    ref_mem[32'h1000 >> 2] = 32'hDEADBEEF;
    ctl_mem[32'h1000 >> 2] = 32'hDEADBEEF;
    access(32'h0000_1000, 32'h0, 4'b0000);
  endtask

  task automatic test_write;
    access(32'h0000_2004, 32'h1234_5678, 4'b0011);
    access(32'h0000_2004, 32'h0, 4'b0000);
  endtask

  task automatic test_back_to_back;
    int unsigned r0, q0;
    r0 = nready; q0 = nreq;
    for (int unsigned i = 0; i < 4; i++) access(32'h5000 + 4 * i, 32'h0, 4'b0000);
    vectors++;
    if (nready - r0 != 4 || nreq - q0 != 4) begin
      miscompares++;
      $display("FAIL back_to_back: %0d ready / %0d requests, required 4 / 4", nready - r0, nreq - q0);
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [3:0] s;
    for (int unsigned i = 0; i < 40; i++) begin
      a = ($urandom & 32'hFC00_0003) | (32'h3000 + 4 * $urandom_range(0, 7));
      s = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      access(a, $urandom, s);
    end
  endtask

  task automatic test_abort;
    int unsigned n;
    mem_addr = 32'h0000_6000; mem_wstrb = 4'b0000; mem_valid = 1'b1;
    n = 0;
    while (!ram_oe && n < 200) begin @(negedge clk); n++; end
    vectors++;
    if (ram_oe !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_setup: ram_oe %b after %0d clocks, required 1", ram_oe, n);
    end
    #2 resetn = 1'b0;
    #1 check_all_zero("async_reset");
    mem_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("held_reset");
    resetn = 1'b1;
    rb_valid = 1'b0;
    @(negedge clk);
    access(32'h0000_1000, 32'h0, 4'b0000);
  endtask

  task automatic test_refresh;
    time t0;
    int unsigned cycles;
    gap_mon = 1'b1; req_seen = 1'b0; long_gaps = 0;
    t0 = $time;
    for (int unsigned i = 0; i < 30; i++) access(32'h7000 + 4 * i, 32'h0, 4'b0000);
    gap_mon = 1'b0;
    cycles = int'(($time - t0) / 10);
    vectors++;
    if (long_gaps == 0 || long_gaps * 160 < cycles) begin
      miscompares++;
      $display("FAIL refresh_rate: %0d refresh gaps in %0d clocks, required >= %0d", long_gaps, cycles, cycles / 160);
    end
  endtask

`ifdef SDRAM_RDBUF_EN
  task automatic test_rdbuf;
    int unsigned q0;
    ref_mem[32'h100 >> 2] = 32'h1122_3344;
    ctl_mem[32'h100 >> 2] = 32'h1122_3344;
    q0 = nreq;
    access(32'h100, 32'h0, 4'b0000);
    access(32'h100, 32'h0, 4'b0000);
    access(32'h100, 32'hAA00_0000, 4'b1000);
    access(32'h100, 32'h0, 4'b0000);
    vectors++;
    if (nreq - q0 != 2) begin
      miscompares++;
      $display("FAIL rdbuf_requests: %0d SDRAM requests, required 2", nreq - q0);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_read;
    test_write;
    test_back_to_back;
    test_random;
    test_abort;
    test_refresh;
`ifdef SDRAM_RDBUF_EN
    test_rdbuf;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

endmodule
